mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_if.sv | 61 ++++++
 rtl/mem_arbiter.sv | 108 ++++++++++
 2 files changed

// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arbiter_if
//  Purpose  : Bundles the two cache requester ports, the shared memory port
//             and the grant status of mem_arbiter.
//  Ports    : i_*  instruction-cache requester (enable/write/addr/data/ack)
//             d_*  data-cache requester (same shape as i_*)
//             mem_* shared memory request/response
//             grant_o ownership status (00 idle, 01 instr, 10 data)
//  Modports : slave  - arbiter side
//             master - requester/memory environment side
//  Revision : 1.0  initial release
// ============================================================================
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 256
);
  logic              i_enable_i;
  logic              i_write_i;
  logic [ADDR_W-1:0] i_addr_i;
  logic [DATA_W-1:0] i_data_i;
  logic              i_ack_o;
  logic [DATA_W-1:0] i_data_o;

  logic              d_enable_i;
  logic              d_write_i;
  logic [ADDR_W-1:0] d_addr_i;
  logic [DATA_W-1:0] d_data_i;
  logic              d_ack_o;
  logic [DATA_W-1:0] d_data_o;

  logic              mem_enable_o;
  logic              mem_write_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_data_o;
  logic [DATA_W-1:0] mem_data_i;
  logic              mem_ack_i;

  logic [1:0]        grant_o;

  modport slave (
    input  i_enable_i, i_write_i, i_addr_i, i_data_i,
    output i_ack_o, i_data_o,
    input  d_enable_i, d_write_i, d_addr_i, d_data_i,
    output d_ack_o, d_data_o,
    output mem_enable_o, mem_write_o, mem_addr_o, mem_data_o,
    input  mem_data_i, mem_ack_i,
    output grant_o
  );

  modport master (
    output i_enable_i, i_write_i, i_addr_i, i_data_i,
    input  i_ack_o, i_data_o,
    output d_enable_i, d_write_i, d_addr_i, d_data_i,
    input  d_ack_o, d_data_o,
    input  mem_enable_o, mem_write_o, mem_addr_o, mem_data_o,
    output mem_data_i, mem_ack_i,
    input  grant_o
  );
endinterface
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arbiter
//  Purpose  : Two-requester (instruction cache / data cache) arbiter for a
//             single shared line-wide memory port. Ties alternate between the
//             requesters; the winner's request is captured on grant and held
//             until the memory acknowledges.
//  Ports    : clk_i  - single clock, rising edge
//             rst_i  - synchronous active-high reset
//             bus    - mem_arbiter_if.slave (requesters, memory, grant status)
//  Revision : 1.0  initial release
// ============================================================================
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 256
) (
  input  logic           clk_i,
  input  logic           rst_i,
  mem_arbiter_if.slave   bus
);

  // State codes double as the grant status encoding.
  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY_I = 2'b01,
    BUSY_D = 2'b10
  } state_e;

  state_e            state_q, state_d;
  logic              last_d_q, last_d_d;   // 1 = data cache served last
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              i_ack, d_ack;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      last_d_q <= 1'b0;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      last_d_q <= last_d_d;
      wr_q     <= wr_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    last_d_d = last_d_q;
    wr_d     = wr_q;
    addr_d   = addr_q;
    data_d   = data_q;
    i_ack    = 1'b0;
    d_ack    = 1'b0;

    case (state_q)
      IDLE: begin
        // Data wins when alone, or on a tie when instruction was not the
        // previous... i.e. when data was not served last (last_d_q = 0).
        // mem_ack_i is deliberately ignored here.
        if (bus.d_enable_i && (!bus.i_enable_i || !last_d_q)) begin
          state_d = BUSY_D;
          wr_d    = bus.d_write_i;
          addr_d  = bus.d_addr_i;
          data_d  = bus.d_data_i;
        end else if (bus.i_enable_i) begin
          state_d = BUSY_I;
          wr_d    = bus.i_write_i;
          addr_d  = bus.i_addr_i;
          data_d  = bus.i_data_i;
        end
      end
      BUSY_I: begin
        // Enable is not re-checked: a dropped request still completes.
        if (bus.mem_ack_i) begin
          i_ack    = !rst_i;
          state_d  = IDLE;
          last_d_d = 1'b0;
        end
      end
      BUSY_D: begin
        if (bus.mem_ack_i) begin
          d_ack    = !rst_i;
          state_d  = IDLE;
          last_d_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.i_ack_o      = i_ack;
  assign bus.d_ack_o      = d_ack;
  assign bus.i_data_o     = bus.mem_data_i;
  assign bus.d_data_o     = bus.mem_data_i;
  assign bus.mem_enable_o = (state_q != IDLE);
  assign bus.mem_write_o  = wr_q;
  assign bus.mem_addr_o   = addr_q;
  assign bus.mem_data_o   = data_q;
  assign bus.grant_o      = state_q;

endmodule
`default_nettype wire
